// File: rtl/cdb_tx_link_ctrl.sv
// cdb_tx_link_ctrl: CHI TX link-layer activation FSM with per-channel credit tracking
module cdb_tx_link_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int CRD_MAX      = 15,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic              clk_out,
    input  logic              rst_out,
    input  logic              link_en,
    input  logic              wake_req,
    input  logic [NUM_CH-1:0] cdb_fifo_nempty,
    input  logic [NUM_CH-1:0] tx_flitpend,
    input  logic [NUM_CH-1:0] tx_flitv,
    input  logic [NUM_CH-1:0] txcrdv,
    input  logic              txlinkactiveack,
    output logic              txlinkactivereq,
    output logic [NUM_CH-1:0] en_flitv,
    output logic [NUM_CH-1:0] link_deactive,
    output logic [1:0]        link_state,
    output logic              crd_err
);
    localparam int CW = $clog2(CRD_MAX + 1);

    typedef enum logic [1:0] {STOP = 2'd0, ACTIVATE = 2'd1, RUN = 2'd2, DEACT = 2'd3} state_t;

    state_t         state_q, state_d;
    logic [15:0]    idle_q, idle_d;
    logic [CW-1:0]  crd_q [NUM_CH];
    logic [CW-1:0]  crd_d [NUM_CH];
    logic           err_q, err_d;
    logic           idle, expired, all_zero;

    assign idle       = ~|cdb_fifo_nempty & ~|tx_flitpend;
    assign expired    = (IDLE_TIMEOUT != 0) && idle && (idle_q == 16'(IDLE_TIMEOUT - 1));
    assign link_state = state_q;
    assign crd_err    = err_q;

    // Credit counters: grant adds, sent/returned flit subtracts, saturate and flag on over/underflow
    always_comb begin
        err_d    = err_q;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            all_zero = all_zero & (crd_q[i] == '0);
            crd_d[i] = crd_q[i];
            if (txcrdv[i] & ~tx_flitv[i]) begin
                if (crd_q[i] == CW'(CRD_MAX)) err_d = 1'b1;
                else crd_d[i] = crd_q[i] + 1'b1;
            end else if (tx_flitv[i] & ~txcrdv[i]) begin
                if (crd_q[i] == '0) err_d = 1'b1;
                else crd_d[i] = crd_q[i] - 1'b1;
            end
        end
    end

    // Link FSM next state and RUN-only saturating idle counter
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP:     state_d = (link_en & ~txlinkactiveack & (|cdb_fifo_nempty | wake_req)) ? ACTIVATE : STOP;
            ACTIVATE: state_d = txlinkactiveack ? RUN : ACTIVATE;
            RUN:      state_d = ((~link_en | expired) & idle) ? DEACT : RUN;
            DEACT:    state_d = (~txlinkactiveack & all_zero) ? STOP : DEACT;
            default:  state_d = STOP;
        endcase
        idle_d = (state_q == RUN && state_d == RUN && idle) ? ((idle_q == 16'hFFFF) ? idle_q : idle_q + 16'd1) : 16'd0;
    end

    // State, counters and registered output decode
    always_ff @(posedge clk_out) begin
        if (rst_out) begin
            state_q         <= STOP;
            idle_q          <= '0;
            err_q           <= 1'b0;
            txlinkactivereq <= 1'b0;
            en_flitv        <= '0;
            link_deactive   <= '0;
            for (int i = 0; i < NUM_CH; i++) crd_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            idle_q          <= idle_d;
            err_q           <= err_d;
            txlinkactivereq <= (state_d == ACTIVATE) || (state_d == RUN);
            en_flitv        <= {NUM_CH{state_d == RUN}};
            link_deactive   <= {NUM_CH{state_d == DEACT}};
            for (int i = 0; i < NUM_CH; i++) crd_q[i] <= crd_d[i];
        end
    end
endmodule

// File: tb/tb_cdb_tx_link_ctrl.sv
// tb_cdb_tx_link_ctrl: directed and randomized checks against a behavioural link/credit model
module tb_cdb_tx_link_ctrl;
    localparam int NUM_CH = 4;
    localparam int CRD_MAX = 15;
    localparam int TO = 4;

    logic clk_out = 1'b0;
    logic rst_out, link_en, wake_req, txlinkactiveack;
    logic [NUM_CH-1:0] cdb_fifo_nempty, tx_flitpend, tx_flitv, txcrdv;
    logic txlinkactivereq, crd_err;
    logic [NUM_CH-1:0] en_flitv, link_deactive;
    logic [1:0] link_state;

    int n_chk = 0;
    int n_fail = 0;

    int m_state, m_idle;
    int m_crd [NUM_CH];
    bit m_err;

    cdb_tx_link_ctrl #(.NUM_CH(NUM_CH), .CRD_MAX(CRD_MAX), .IDLE_TIMEOUT(TO)) dut (
        .clk_out(clk_out), .rst_out(rst_out), .link_en(link_en), .wake_req(wake_req),
        .cdb_fifo_nempty(cdb_fifo_nempty), .tx_flitpend(tx_flitpend), .tx_flitv(tx_flitv),
        .txcrdv(txcrdv), .txlinkactiveack(txlinkactiveack), .txlinkactivereq(txlinkactivereq),
        .en_flitv(en_flitv), .link_deactive(link_deactive), .link_state(link_state), .crd_err(crd_err)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: link states 0..3 as integers, credits as plain integer counts
    task automatic model_step();
        int nxt;
        bit idle, all0, expd;
        if (rst_out) begin
            m_state = 0; m_idle = 0; m_err = 0;
            for (int i = 0; i < NUM_CH; i++) m_crd[i] = 0;
            return;
        end
        idle = (cdb_fifo_nempty == 0) && (tx_flitpend == 0);
        all0 = 1;
        for (int i = 0; i < NUM_CH; i++) if (m_crd[i] != 0) all0 = 0;
        expd = (TO != 0) && (m_idle == TO - 1) && idle;
        nxt = m_state;
        if (m_state == 0 && link_en && !txlinkactiveack && (cdb_fifo_nempty != 0 || wake_req)) nxt = 1;
        if (m_state == 1 && txlinkactiveack) nxt = 2;
        if (m_state == 2 && (!link_en || expd) && idle) nxt = 3;
        if (m_state == 3 && !txlinkactiveack && all0) nxt = 0;
        m_idle = (m_state == 2 && nxt == 2 && idle) ? ((m_idle < 65535) ? m_idle + 1 : m_idle) : 0;
        m_state = nxt;
        for (int i = 0; i < NUM_CH; i++) begin
            int v;
            v = m_crd[i] + int'(txcrdv[i]) - int'(tx_flitv[i]);
            if (v > CRD_MAX) begin v = CRD_MAX; m_err = 1; end
            if (v < 0) begin v = 0; m_err = 1; end
            m_crd[i] = v;
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        model_step();
        #1;
        chk("link_state", 32'(link_state), 32'(m_state));
        chk("txlinkactivereq", 32'(txlinkactivereq), 32'(m_state == 1 || m_state == 2));
        chk("en_flitv", 32'(en_flitv), (m_state == 2) ? 32'hF : 32'h0);
        chk("link_deactive", 32'(link_deactive), (m_state == 3) ? 32'hF : 32'h0);
        chk("crd_err", 32'(crd_err), 32'(m_err));
    endtask

    task automatic idle_inputs();
        rst_out = 0; link_en = 0; wake_req = 0; txlinkactiveack = 0;
        cdb_fifo_nempty = 0; tx_flitpend = 0; tx_flitv = 0; txcrdv = 0;
    endtask

    initial begin
        idle_inputs();
        rst_out = 1;
        m_state = 0; m_idle = 0; m_err = 0;
        for (int i = 0; i < NUM_CH; i++) m_crd[i] = 0;
        tick(); tick();
        rst_out = 0;

        // activation, ch2 gets 5 credits in RUN, then mid-run reset
        link_en = 1; cdb_fifo_nempty = 4'b0001;
        tick();
        chk("act_state", 32'(link_state), 32'd1);
        chk("act_req", 32'(txlinkactivereq), 32'd1);
        tick(); tick();
        txlinkactiveack = 1;
        tick();
        chk("run_state", 32'(link_state), 32'd2);
        chk("run_en", 32'(en_flitv), 32'hF);
        txcrdv = 4'b0100;
        repeat (5) tick();
        txcrdv = 0; rst_out = 1;
        tick(); tick();
        rst_out = 0; txlinkactiveack = 0; cdb_fifo_nempty = 0; link_en = 0;
        chk("rst_state", 32'(link_state), 32'd0);
        chk("rst_req", 32'(txlinkactivereq), 32'd0);
        chk("rst_err", 32'(crd_err), 32'd0);
        tx_flitv = 4'b0100;
        tick();
        chk("rst_cnt_zero_underflow", 32'(crd_err), 32'd1);
        tx_flitv = 0; rst_out = 1;
        tick();
        rst_out = 0;

        // credits on ch1 in RUN, deactivate, drain, stop
        link_en = 1; cdb_fifo_nempty = 4'b0001;
        tick();
        txlinkactiveack = 1;
        tick();
        txcrdv = 4'b0010;
        repeat (3) tick();
        txcrdv = 0; link_en = 0; cdb_fifo_nempty = 0;
        tick();
        chk("deact_state", 32'(link_state), 32'd3);
        chk("deact_ld", 32'(link_deactive), 32'hF);
        chk("deact_req", 32'(txlinkactivereq), 32'd0);
        tx_flitv = 4'b0010;
        repeat (3) tick();
        tx_flitv = 0;
        tick();
        chk("deact_hold_ack", 32'(link_state), 32'd3);
        txlinkactiveack = 0;
        tick();
        chk("stop_state", 32'(link_state), 32'd0);

        // idle timeout with an activity pulse restarting the count
        link_en = 1; wake_req = 1;
        tick();
        wake_req = 0; txlinkactiveack = 1;
        tick();
        tick(); tick();
        tx_flitpend = 4'b0001;
        tick();
        tx_flitpend = 0;
        repeat (3) tick();
        chk("idle_no_expire", 32'(link_state), 32'd2);
        tick();
        chk("idle_expire", 32'(link_state), 32'd3);
        txlinkactiveack = 0;
        tick();

        // deactivation blocked by a non-empty FIFO
        cdb_fifo_nempty = 4'b1000;
        tick();
        txlinkactiveack = 1;
        tick();
        link_en = 0;
        repeat (3) tick();
        chk("blocked_state", 32'(link_state), 32'd2);
        chk("blocked_en", 32'(en_flitv), 32'hF);
        cdb_fifo_nempty = 0;
        tick();
        chk("unblocked_state", 32'(link_state), 32'd3);
        txlinkactiveack = 0;
        tick();

        // credit saturation on ch2, then overflow, then underflow on ch0
        txcrdv = 4'b0100;
        repeat (15) tick();
        chk("crd_full_noerr", 32'(crd_err), 32'd0);
        tx_flitv = 4'b0100;
        tick();
        chk("crd_both_noerr", 32'(crd_err), 32'd0);
        tx_flitv = 0;
        tick();
        chk("crd_overflow", 32'(crd_err), 32'd1);
        txcrdv = 0; rst_out = 1;
        tick();
        rst_out = 0;
        tx_flitv = 4'b0001;
        tick();
        chk("crd_underflow", 32'(crd_err), 32'd1);
        tx_flitv = 0;

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst_out = ($urandom_range(199) == 0);
            link_en = ($urandom_range(9) != 0);
            wake_req = ($urandom_range(7) == 0);
            cdb_fifo_nempty = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0;
            tx_flitpend = ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0;
            txcrdv = 4'($urandom) & 4'($urandom);
            tx_flitv = 4'($urandom) & 4'($urandom);
            if ($urandom_range(3) != 0) txlinkactiveack = txlinkactivereq;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
